// File: rtl/screen_ctrl.sv
// Game-flow screen sequencer: START -> GAME -> PLAYER_1/PLAYER_2 -> START, with changes committed on vblnk rise.
// Optional win-screen auto-return is compiled in with SCREEN_AUTO_RETURN_EN.
module screen_ctrl #(
  parameter int unsigned WIN_POINTS      = 10,
  parameter int unsigned WIN_HOLD_FRAMES = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       vblnk,
  input  logic [4:0] points_p1,
  input  logic [4:0] points_p2,
  output logic [1:0] screen,
  output logic       game_rst,
  output logic       frame_tick
);

  localparam int unsigned PTS_W = 5;

  localparam logic [1:0] START    = 2'd0;
  localparam logic [1:0] GAME     = 2'd1;
  localparam logic [1:0] PLAYER_1 = 2'd2;
  localparam logic [1:0] PLAYER_2 = 2'd3;

  // Elaboration-time sanity check on the configuration
  if (WIN_POINTS > 31 || WIN_HOLD_FRAMES == 0) begin : g_bad_cfg
    $error("screen_ctrl: WIN_POINTS must fit 5 bits and WIN_HOLD_FRAMES must be nonzero");
  end

  logic       start_d;
  logic       vblnk_d;
  logic       start_edge;
  logic       frame_start;
  logic       pend_valid, pend_valid_nxt;
  logic [1:0] pending, pending_nxt;
  logic [1:0] screen_nxt;
  logic       game_rst_nxt;
  logic       win_mask, win_mask_nxt;
  logic       hold_done;

  assign start_edge  = start_btn & ~start_d;
  assign frame_start = vblnk & ~vblnk_d;

`ifdef SCREEN_AUTO_RETURN_EN
  localparam int unsigned CNT_W = $clog2(WIN_HOLD_FRAMES + 1);

  logic [CNT_W-1:0] frame_cnt, frame_cnt_nxt;

  assign hold_done = (frame_cnt == CNT_W'(WIN_HOLD_FRAMES));

  // Win-screen frame counter: cleared on entry, saturating
  always_comb begin
    frame_cnt_nxt = frame_cnt;
    if (pend_valid && frame_start && pending[1]) begin
      frame_cnt_nxt = '0;
    end else if (screen[1] && frame_start && !hold_done) begin
      frame_cnt_nxt = frame_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) frame_cnt <= '0;
    else     frame_cnt <= frame_cnt_nxt;
  end
`else
  assign hold_done = 1'b0;
`endif

  // Next-state: commit a pending request at a frame boundary, else latch new events
  always_comb begin
    screen_nxt     = screen;
    pend_valid_nxt = pend_valid;
    pending_nxt    = pending;
    game_rst_nxt   = 1'b0;
    win_mask_nxt   = win_mask;

    if (frame_start) win_mask_nxt = 1'b0;

    if (pend_valid) begin
      if (frame_start) begin
        screen_nxt     = pending;
        pend_valid_nxt = 1'b0;
        if (pending == GAME) begin
          game_rst_nxt = 1'b1;
          win_mask_nxt = 1'b1;
        end
      end
    end else begin
      case (screen)
        START: begin
          if (start_edge) begin
            pend_valid_nxt = 1'b1;
            pending_nxt    = GAME;
          end
        end
        GAME: begin
          if (!win_mask) begin
            if (points_p1 >= PTS_W'(WIN_POINTS)) begin
              pend_valid_nxt = 1'b1;
              pending_nxt    = PLAYER_1;
            end else if (points_p2 >= PTS_W'(WIN_POINTS)) begin
              pend_valid_nxt = 1'b1;
              pending_nxt    = PLAYER_2;
            end
          end
        end
        default: begin
          if (start_edge || hold_done) begin
            pend_valid_nxt = 1'b1;
            pending_nxt    = START;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_d    <= 1'b1;
      vblnk_d    <= 1'b0;
      frame_tick <= 1'b0;
      screen     <= START;
      game_rst   <= 1'b0;
      pend_valid <= 1'b0;
      pending    <= START;
      win_mask   <= 1'b0;
    end else begin
      start_d    <= start_btn;
      vblnk_d    <= vblnk;
      frame_tick <= frame_start;
      screen     <= screen_nxt;
      game_rst   <= game_rst_nxt;
      pend_valid <= pend_valid_nxt;
      pending    <= pending_nxt;
      win_mask   <= win_mask_nxt;
    end
  end

endmodule
